// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep: drives every input vector into three forms of a
// boolean function, records the original's truth table and counts disagreements.
module tt_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   f_orig,
  input  logic                   f_sop,
  input  logic                   f_pos,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   truth_table,
  output logic [N_IN:0]          mismatch_count,
  output logic [N_IN-1:0]        first_fail,
  output logic                   first_fail_valid,
  output logic [1:0]             state_dbg
);

  // Handshake: start is sampled only in IDLE (ignored elsewhere, never queued);
  // busy is high from the first sweep cycle through the done cycle; done is a
  // single-cycle pulse, and results stay stable until the next accepted start.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = {N_IN{1'b1}};

  state_t     state, state_next;
  logic [3:0] settle_cnt;
  logic       pass_q;
  logic       vec_fail;

  assign vec_fail  = (f_sop ^ f_orig) | (f_pos ^ f_orig);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = S_SAMPLE;
      S_SAMPLE: state_next = (vec_out == VEC_LAST) ? S_DONE : S_SETTLE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // pass is live from the done cycle; before that it shows the previous sweep.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
    pass = (state == S_DONE) ? (mismatch_count == '0) : pass_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out          <= '0;
      settle_cnt       <= '0;
      truth_table      <= '0;
      mismatch_count   <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_out          <= '0;
            settle_cnt       <= '0;
            truth_table      <= '0;
            mismatch_count   <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        S_SAMPLE: begin
          truth_table[vec_out] <= f_orig;
          // At most 2^N_IN increments per sweep, so N_IN+1 bits never wrap.
          if (vec_fail) begin
            mismatch_count <= mismatch_count + (N_IN+1)'(1);
            if (!first_fail_valid) begin
              first_fail       <= vec_out;
              first_fail_valid <= 1'b1;
            end
          end
          if (vec_out != VEC_LAST) begin
            vec_out    <= vec_out + N_IN'(1);
            settle_cnt <= '0;
          end
        end
        S_DONE: pass_q <= (mismatch_count == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three instances (defaults, SETTLE=3, N_IN=3) with
// a reference model feeding the function inputs and a scoreboard of sweep results.
module tb_tt_sweep_checker;

  localparam int W = 27;  // {truth_table[15:0], mismatch_count[4:0], first_fail[3:0], ffv, pass}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start;
  logic [1:0] mode;
  int sel;

  always #5 clk = ~clk;

  // instance 0: N_IN=4, SETTLE=1, fault-injectable forms
  logic [3:0]  vec0, ff0;
  logic        fo0, fs0, fp0, busy0, done0, pass0, ffv0, g0;
  logic [15:0] tt0;
  logic [4:0]  mc0;
  logic [1:0]  st0;
  // instance 1: N_IN=4, SETTLE=3
  logic [3:0]  vec1, ff1;
  logic        fo1, busy1, done1, pass1, ffv1;
  logic [15:0] tt1;
  logic [4:0]  mc1;
  logic [1:0]  st1;
  // instance 2: N_IN=3, SETTLE=1, f = A&C
  logic [2:0]  vec2, ff2;
  logic        fo2, busy2, done2, pass2, ffv2;
  logic [7:0]  tt2;
  logic [3:0]  mc2;
  logic [1:0]  st2;

  function automatic logic g4(input logic [3:0] v);
    return (v[3] & ~v[2] & v[1]) | (~v[3] & ~v[2]) | (v[3] & v[2] & ~v[1] & v[0]);
  endfunction

  always_comb begin
    g0  = g4(vec0);
    fo0 = g0;
    fs0 = (mode == 2'd2) ? ~g0 : g0;
    fp0 = (mode == 2'd1 && vec0 == 4'd5) ? ~g0 : g0;
  end
  assign fo1 = g4(vec1);
  assign fo2 = vec2[2] & vec2[0];

  tt_sweep_checker #(.N_IN(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .vec_out(vec0),
    .f_orig(fo0), .f_sop(fs0), .f_pos(fp0), .busy(busy0), .done(done0), .pass(pass0),
    .truth_table(tt0), .mismatch_count(mc0), .first_fail(ff0),
    .first_fail_valid(ffv0), .state_dbg(st0));

  tt_sweep_checker #(.N_IN(4), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .vec_out(vec1),
    .f_orig(fo1), .f_sop(fo1), .f_pos(fo1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .mismatch_count(mc1), .first_fail(ff1),
    .first_fail_valid(ffv1), .state_dbg(st1));

  tt_sweep_checker #(.N_IN(3), .SETTLE(1)) u_dut_n3 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .vec_out(vec2),
    .f_orig(fo2), .f_sop(fo2), .f_pos(fo2), .busy(busy2), .done(done2), .pass(pass2),
    .truth_table(tt2), .mismatch_count(mc2), .first_fail(ff2),
    .first_fail_valid(ffv2), .state_dbg(st2));

  // selected instance, zero-extended to the widest shape
  logic [3:0]  m_vec, m_ff;
  logic        m_busy, m_done, m_pass, m_ffv;
  logic [15:0] m_tt;
  logic [4:0]  m_mc;
  logic [1:0]  m_st;

  always_comb begin
    m_vec = vec0; m_ff = ff0; m_busy = busy0; m_done = done0; m_pass = pass0;
    m_ffv = ffv0; m_tt = tt0; m_mc = mc0; m_st = st0;
    if (sel == 1) begin
      m_vec = vec1; m_ff = ff1; m_busy = busy1; m_done = done1; m_pass = pass1;
      m_ffv = ffv1; m_tt = tt1; m_mc = mc1; m_st = st1;
    end else if (sel == 2) begin
      m_vec = {1'b0, vec2}; m_ff = {1'b0, ff2}; m_busy = busy2; m_done = done2;
      m_pass = pass2; m_ffv = ffv2; m_tt = {8'h00, tt2}; m_mc = {1'b0, mc2}; m_st = st2;
    end
  end

  logic [W-1:0] exp_q[$];
  logic model_pass [3];
  int total = 0;
  int bad = 0;

  function automatic logic [W-1:0] ref_result(input int m, input int nin);
    logic [15:0] tt;
    logic [4:0]  mc;
    logic [3:0]  ff, v;
    logic        ffv, o, s, p;
    tt = '0; mc = '0; ff = '0; ffv = 1'b0;
    for (int i = 0; i < (1 << nin); i++) begin
      v = 4'(i);
      o = (nin == 4) ? g4(v) : (v[2] & v[0]);
      s = (m == 2) ? ~o : o;
      p = (m == 1 && i == 5) ? ~o : o;
      tt[i] = o;
      if (s != o || p != o) begin
        mc = mc + 5'd1;
        if (!ffv) begin ff = v; ffv = 1'b1; end
      end
    end
    return {tt, mc, ff, ffv, (mc == 5'd0)};
  endfunction

  // Called at a negedge: start is seen at the next posedge (cycle 0).
  task automatic start_sweep(input int m);
    mode  = 2'(m);
    start = 1'b1;
    exp_q.push_back(ref_result(m, (sel == 2) ? 3 : 4));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Walks cycles 1..done+1 at negedges; optional stray start pulse or reset abort.
  task automatic monitor_sweep(input int pulse_at, input int abort_at);
    int settle, nin, exp_done;
    logic [W-1:0] e;
    logic [3:0] ev;
    settle   = (sel == 1) ? 3 : 1;
    nin      = (sel == 2) ? 3 : 4;
    exp_done = 1 + (1 << nin) * (settle + 1);
    for (int c = 1; c <= exp_done + 1; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (c == abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (m_vec !== 4'd0) begin bad++; $display("FAIL abort_vec: got %0h want 0", m_vec); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", m_busy); end
        total++; if (m_done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", m_done); end
        total++; if (m_pass !== 1'b0) begin bad++; $display("FAIL abort_pass: got %b want 0", m_pass); end
        total++; if (m_tt !== 16'h0) begin bad++; $display("FAIL abort_tt: got %0h want 0", m_tt); end
        total++; if (m_mc !== 5'd0) begin bad++; $display("FAIL abort_mc: got %0d want 0", m_mc); end
        total++; if (m_ff !== 4'd0) begin bad++; $display("FAIL abort_ff: got %0d want 0", m_ff); end
        total++; if (m_ffv !== 1'b0) begin bad++; $display("FAIL abort_ffv: got %b want 0", m_ffv); end
        total++; if (m_st !== 2'd0) begin bad++; $display("FAIL abort_state: got %0d want 0", m_st); end
        void'(exp_q.pop_front());
        model_pass = '{default: 1'b0};
        repeat (3) begin
          @(negedge clk);
          total++; if (m_done !== 1'b0 || m_busy !== 1'b0) begin
            bad++; $display("FAIL abort_quiet: got done=%b busy=%b want 0 0", m_done, m_busy);
          end
        end
        rst_n = 1'b1;
        return;
      end
      total++; if (m_busy !== (c <= exp_done)) begin
        bad++; $display("FAIL busy_c%0d: got %b want %b", c, m_busy, (c <= exp_done));
      end
      total++; if (m_done !== (c == exp_done)) begin
        bad++; $display("FAIL done_c%0d: got %b want %b", c, m_done, (c == exp_done));
      end
      ev = (c < exp_done) ? 4'((c - 1) / (settle + 1)) : 4'((1 << nin) - 1);
      total++; if (m_vec !== ev) begin
        bad++; $display("FAIL vec_c%0d: got %0d want %0d", c, m_vec, ev);
      end
      if (c != exp_done) begin
        total++; if (m_pass !== model_pass[sel]) begin
          bad++; $display("FAIL pass_held_c%0d: got %b want %b", c, m_pass, model_pass[sel]);
        end
      end else if (exp_q.size() == 0) begin
        total++; bad++; $display("FAIL scoreboard_empty: got 0 entries want 1");
      end else begin
        e = exp_q.pop_front();
        total++; if (m_tt !== e[26:11]) begin bad++; $display("FAIL truth_table: got %0h want %0h", m_tt, e[26:11]); end
        total++; if (m_mc !== e[10:6]) begin bad++; $display("FAIL mismatch_count: got %0d want %0d", m_mc, e[10:6]); end
        total++; if (m_ff !== e[5:2]) begin bad++; $display("FAIL first_fail: got %0d want %0d", m_ff, e[5:2]); end
        total++; if (m_ffv !== e[1]) begin bad++; $display("FAIL first_fail_valid: got %b want %b", m_ffv, e[1]); end
        total++; if (m_pass !== e[0]) begin bad++; $display("FAIL pass: got %b want %b", m_pass, e[0]); end
        model_pass[sel] = e[0];
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    @(negedge clk);
    total++; if (m_vec !== 4'd0) begin bad++; $display("FAIL reset_vec: got %0h want 0", m_vec); end
    total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    total++; if (m_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", m_done); end
    total++; if (m_pass !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", m_pass); end
    total++; if (m_tt !== 16'h0) begin bad++; $display("FAIL reset_tt: got %0h want 0", m_tt); end
    total++; if (m_mc !== 5'd0) begin bad++; $display("FAIL reset_mc: got %0d want 0", m_mc); end
    total++; if (m_ff !== 4'd0) begin bad++; $display("FAIL reset_ff: got %0d want 0", m_ff); end
    total++; if (m_ffv !== 1'b0) begin bad++; $display("FAIL reset_ffv: got %b want 0", m_ffv); end
    total++; if (m_st !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", m_st); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct();
    sel = 0; start_sweep(0); monitor_sweep(0, 0);
  endtask

  task automatic test_single_fault();
    sel = 0; start_sweep(1); monitor_sweep(0, 0);
  endtask

  task automatic test_complement();
    sel = 0; start_sweep(2); monitor_sweep(0, 0);
  endtask

  // start in the cycle busy falls; pass must keep 0 until the new done
  task automatic test_back_to_back();
    sel = 0; start_sweep(0); monitor_sweep(0, 0);
  endtask

  task automatic test_settle3();
    sel = 1; start_sweep(0); monitor_sweep(0, 0);
  endtask

  task automatic test_ignored_start_and_abort();
    sel = 0;
    start_sweep(0); monitor_sweep(10, 0);
    start_sweep(0); monitor_sweep(0, 20);
    start_sweep(0); monitor_sweep(0, 0);
  endtask

  task automatic test_n3();
    sel = 2; start_sweep(0); monitor_sweep(0, 0);
  endtask

  initial begin
    start = 1'b0;
    mode = 2'd0;
    sel = 0;
    model_pass = '{default: 1'b0};
    repeat (2) @(negedge clk);
    test_reset();
    test_correct();
    test_single_fault();
    test_complement();
    test_back_to_back();
    test_settle3();
    test_ignored_start_and_abort();
    test_n3();
    if (exp_q.size() != 0) begin
      total++; bad++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
